// File: rtl/dither_spi_tx.sv
// dither_spi_tx: reads the finished dithered frame out of pixel SRAM
// in address order and shifts each pixel MSB-first onto SPI MISO.
module dither_spi_tx #(
    parameter int IMAGEX           = 16,
    parameter int IMAGEY           = 16,
    parameter int IMAGE_SIZE       = IMAGEX * IMAGEY,
    parameter int IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int RGB_SIZE         = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    output logic                        sram_rd,
    output logic [IMAGE_ADDR_WIDTH-1:0] sram_addr,
    input  logic [RGB_SIZE-1:0]         sram_rdata,
    input  logic                        spi_clk,
    input  logic                        spi_cs_n,
    output logic                        spi_miso,
    output logic                        spi_miso_oe,
    output logic                        mcu_rx_rdy,
    output logic                        busy,
    output logic                        done
);

    localparam int CNT_W = $clog2(RGB_SIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RGB_SIZE - 1);
    localparam logic [IMAGE_ADDR_WIDTH-1:0] LAST_ADDR =
        IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_READY,
        S_NEXT
    } state_t;

    state_t state, state_d;

    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_sync;
    logic       cs_rise;

    logic [IMAGE_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [RGB_SIZE-1:0]         shift_q, shift_d;
    logic [RGB_SIZE-1:0]         hold_q, hold_d;

    // Two sync flops plus one history flop on each SPI pin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q <= '0;
            cs_q   <= '1;
        end else begin
            sclk_q <= {sclk_q[1:0], spi_clk};
            cs_q   <= {cs_q[1:0], spi_cs_n};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_sync   = cs_q[1];
    assign cs_rise   = cs_q[1] & ~cs_q[2];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            hold_q  <= '0;
        end else begin
            state   <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d    = state;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        sram_rd    = 1'b0;
        mcu_rx_rdy = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            S_IDLE: begin
                busy   = 1'b0;
                addr_d = '0;
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                sram_rd = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                hold_d  = sram_rdata;
                shift_d = sram_rdata;
                cnt_d   = '0;
                state_d = S_READY;
            end
            S_READY: begin
                mcu_rx_rdy = 1'b1;
                if (cs_rise && cnt_q != '0) begin
                    shift_d = hold_q;
                    cnt_d   = '0;
                end else if (!cs_sync) begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            state_d = S_NEXT;
                        end
                    end else if (sclk_fall && cnt_q != '0) begin
                        // A fall before the first rise is the previous
                        // byte's trailing edge; the MSB must stay put.
                        shift_d = {shift_q[RGB_SIZE-2:0], 1'b0};
                    end
                end
            end
            S_NEXT: begin
                if (addr_q == LAST_ADDR) begin
                    done    = 1'b1;
                    addr_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sram_addr   = addr_q;
    assign spi_miso    = ~cs_sync & shift_q[RGB_SIZE-1];
    assign spi_miso_oe = ~cs_sync;

endmodule

// File: tb/tb_dither_spi_tx.sv
// tb_dither_spi_tx: directed bench acting as SRAM and SPI master
// for the dithered-frame readback transmitter.
module tb_dither_spi_tx;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       sram_rd;
    logic [7:0] sram_addr;
    logic [7:0] sram_rdata = 8'h00;
    logic       spi_clk = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic       mcu_rx_rdy;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rd_cnt = 0;

    logic [7:0] mem [256];
    logic       rd_pend = 1'b0;
    logic [7:0] rd_val = 8'h00;
    logic [7:0] rx;

    dither_spi_tx dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .sram_rd     (sram_rd),
        .sram_addr   (sram_addr),
        .sram_rdata  (sram_rdata),
        .spi_clk     (spi_clk),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .mcu_rx_rdy  (mcu_rx_rdy),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // SRAM model: request seen mid-cycle, data valid the next cycle.
    always @(negedge clk) begin
        rd_pend = sram_rd;
        rd_val  = mem[sram_addr];
        if (done) done_cnt++;
        if (sram_rd) rd_cnt++;
    end

    always @(posedge clk) begin
        if (rd_pend) sram_rdata <= rd_val;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        start    = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_rdy();
        int i;
        for (i = 0; i < 2000; i++) begin
            if (mcu_rx_rdy) break;
            tick(1);
        end
        if (i == 2000) begin
            checks++;
            errors++;
            $display("FAIL wait_rdy: mcu_rx_rdy=%b required 1 (timeout)",
                     mcu_rx_rdy);
        end
    endtask

    task automatic xfer_bits(input int n);
        for (int i = 0; i < n; i++) begin
            rx      = {rx[6:0], spi_miso};
            spi_clk = 1'b1;
            tick(4);
            spi_clk = 1'b0;
            tick(4);
        end
    endtask

    task automatic recv_byte();
        wait_rdy();
        tick(2);
        rx = 8'h00;
        xfer_bits(8);
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        spi_cs_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            spi_clk = ~spi_clk;
            tick(1);
        end
        checks++;
        if ({sram_rd, spi_miso, spi_miso_oe, mcu_rx_rdy, busy, done}
            !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs: got %b required 000000",
                     {sram_rd, spi_miso, spi_miso_oe, mcu_rx_rdy, busy, done});
        end
        checks++;
        if (sram_addr !== 8'h00) begin
            errors++;
            $display("FAIL reset_addr: got %h required 00", sram_addr);
        end
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        tick(1);
        reset_n = 1'b1;
        rd_cnt  = 0;
        tick(20);
        checks++;
        if (rd_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_read: rd_cnt=%0d busy=%b required 0 0",
                     rd_cnt, busy);
        end
    endtask

    task automatic test_single_pixel();
        do_reset();
        mem[0] = 8'hA5;
        pulse_start();
        checks++;
        if ({sram_rd, busy} !== 2'b11) begin
            errors++;
            $display("FAIL fetch_cycle: rd,busy=%b required 11",
                     {sram_rd, busy});
        end
        tick(2);
        checks++;
        if ({mcu_rx_rdy, sram_addr} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL ready_cycle3: rdy=%b addr=%h required 1 00",
                     mcu_rx_rdy, sram_addr);
        end
        spi_cs_n = 1'b0;
        tick(4);
        rx = 8'h00;
        xfer_bits(7);
        rx      = {rx[6:0], spi_miso};
        spi_clk = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({mcu_rx_rdy, sram_rd} !== 2'b00) begin
            errors++;
            $display("FAIL next_cycle: rdy,rd=%b required 00",
                     {mcu_rx_rdy, sram_rd});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({sram_rd, sram_addr} !== {1'b1, 8'h01}) begin
            errors++;
            $display("FAIL refetch: rd=%b addr=%h required 1 01",
                     sram_rd, sram_addr);
        end
        @(negedge clk);
        spi_clk = 1'b0;
        tick(4);
        checks++;
        if (rx !== 8'hA5) begin
            errors++;
            $display("FAIL single_byte: got %h required a5", rx);
        end
        spi_cs_n = 1'b1;
    endtask

    task automatic test_full_frame();
        int bad;
        do_reset();
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'((i * 73 + 29) ^ (i >> 3));
        end
        done_cnt = 0;
        bad      = 0;
        pulse_start();
        spi_cs_n = 1'b0;
        for (int i = 0; i < 256; i++) begin
            recv_byte();
            checks++;
            if (rx !== mem[i]) begin
                errors++;
                if (bad < 8) begin
                    $display("FAIL frame_byte[%0d]: got %h required %h",
                             i, rx, mem[i]);
                end
                bad++;
            end
        end
        tick(6);
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL done_count: got %0d required 1", done_cnt);
        end
        checks++;
        if ({busy, sram_addr} !== 9'h000) begin
            errors++;
            $display("FAIL frame_end: busy=%b addr=%h required 0 00",
                     busy, sram_addr);
        end
        spi_cs_n = 1'b1;
    endtask

    task automatic test_cs_abort();
        do_reset();
        mem[0] = 8'h3C;
        pulse_start();
        wait_rdy();
        spi_cs_n = 1'b0;
        tick(4);
        rx = 8'h00;
        xfer_bits(3);
        checks++;
        if (rx[2:0] !== 3'b001) begin
            errors++;
            $display("FAIL abort_partial: got %b required 001", rx[2:0]);
        end
        spi_cs_n = 1'b1;
        tick(4);
        checks++;
        if ({sram_addr, mcu_rx_rdy, spi_miso_oe, spi_miso}
            !== {8'h00, 3'b100}) begin
            errors++;
            $display("FAIL abort_hold: addr=%h rdy=%b oe=%b miso=%b req 00 1 0 0",
                     sram_addr, mcu_rx_rdy, spi_miso_oe, spi_miso);
        end
        spi_cs_n = 1'b0;
        tick(4);
        rx = 8'h00;
        xfer_bits(8);
        checks++;
        if (rx !== 8'h3C) begin
            errors++;
            $display("FAIL abort_resend: got %h required 3c", rx);
        end
        checks++;
        if (sram_addr !== 8'h01) begin
            errors++;
            $display("FAIL abort_advance: addr=%h required 01", sram_addr);
        end
        spi_cs_n = 1'b1;
    endtask

    task automatic test_ignored_and_reset();
        int bad;
        bad = 0;
        do_reset();
        pulse_start();
        spi_cs_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            recv_byte();
            checks++;
            if (rx !== mem[i]) begin
                errors++;
                $display("FAIL pre_byte[%0d]: got %h required %h",
                         i, rx, mem[i]);
            end
        end
        spi_cs_n = 1'b1;
        wait_rdy();
        for (int i = 0; i < 4; i++) begin
            spi_clk = 1'b1;
            tick(4);
            spi_clk = 1'b0;
            tick(4);
        end
        checks++;
        if ({mcu_rx_rdy, sram_addr} !== {1'b1, 8'h05}) begin
            errors++;
            $display("FAIL clk_cs_high: rdy=%b addr=%h required 1 05",
                     mcu_rx_rdy, sram_addr);
        end
        spi_cs_n = 1'b0;
        tick(4);
        rx = 8'h00;
        xfer_bits(3);
        pulse_start();
        checks++;
        if ({busy, sram_addr} !== {1'b1, 8'h05}) begin
            errors++;
            $display("FAIL start_ignored: busy=%b addr=%h required 1 05",
                     busy, sram_addr);
        end
        xfer_bits(5);
        checks++;
        if (rx !== mem[5]) begin
            errors++;
            $display("FAIL byte5: got %h required %h", rx, mem[5]);
        end
        for (int i = 6; i < 100; i++) begin
            recv_byte();
            checks++;
            if (rx !== mem[i]) begin
                errors++;
                if (bad < 8) begin
                    $display("FAIL post_byte[%0d]: got %h required %h",
                             i, rx, mem[i]);
                end
                bad++;
            end
        end
        wait_rdy();
        tick(2);
        rx = 8'h00;
        xfer_bits(4);
        spi_clk = 1'b1;
        tick(2);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, spi_miso_oe, spi_miso, mcu_rx_rdy, sram_addr}
            !== 12'h000) begin
            errors++;
            $display("FAIL async_reset: busy=%b oe=%b miso=%b rdy=%b addr=%h",
                     busy, spi_miso_oe, spi_miso, mcu_rx_rdy, sram_addr);
        end
        spi_clk  = 1'b0;
        spi_cs_n = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(2);
        pulse_start();
        checks++;
        if ({sram_rd, sram_addr} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL restart_fetch: rd=%b addr=%h required 1 00",
                     sram_rd, sram_addr);
        end
        spi_cs_n = 1'b0;
        recv_byte();
        checks++;
        if (rx !== mem[0]) begin
            errors++;
            $display("FAIL restart_byte: got %h required %h", rx, mem[0]);
        end
        spi_cs_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_single_pixel();
        test_full_frame();
        test_cs_abort();
        test_ignored_and_reset();
        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
